// File: rtl/mux_8line_8bit_rr_pkg.sv
// Shared definitions for the 8-line round-robin gathering mux.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package mux_8line_8bit_rr_pkg;

   localparam int MUX_NLINES = 8;
   localparam int MUX_WIDTH  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Round-robin pointer step; the 3-bit width provides the wrap from 7 to 0.
   function automatic logic [2:0] ptr_inc(input logic [2:0] p);
      return p + 3'd1;
   endfunction

endpackage

// File: rtl/mux_8line_8bit_rr_pick.sv
// Round-robin picker: first requesting line scanning ptr, ptr+1, ... ptr+7.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick_8 (
   input  logic [7:0] req,
   input  logic [2:0] ptr,
   output logic [2:0] pick,
   output logic       any
);

   // Scan from the highest offset down so the lowest offset hit is what remains.
   always_comb begin
      logic [2:0] idx;
      pick = 3'd0;
      any  = 1'b0;
      idx  = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = ptr + 3'(k);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_8line_8bit_rr.sv
// Gathers one byte at a time from 8 request lines onto one registered output.
// Latency: 1 cycle from req to out_valid; one byte per cycle back-to-back.
// Backpressure: out_ready low freezes out/sel_out/out_valid; no grants are issued.
module mux_8line_8bit_rr
   import mux_8line_8bit_rr_pkg::*;
#(
   parameter int NLINES = MUX_NLINES,   // only 8 is supported
   parameter int WIDTH  = MUX_WIDTH
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [WIDTH-1:0]  in0,
   input  logic [WIDTH-1:0]  in1,
   input  logic [WIDTH-1:0]  in2,
   input  logic [WIDTH-1:0]  in3,
   input  logic [WIDTH-1:0]  in4,
   input  logic [WIDTH-1:0]  in5,
   input  logic [WIDTH-1:0]  in6,
   input  logic [WIDTH-1:0]  in7,
   input  logic [NLINES-1:0] req,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic [2:0]        sel_out,
   output logic [NLINES-1:0] grant
);

   state_t           state;
   logic [2:0]       ptr;
   logic [2:0]       base;
   logic [2:0]       pick;
   logic             any;
   logic [WIDTH-1:0] mux_dat;

   // While holding, a re-pick happens only on acceptance, and it starts just past
   // the line being accepted; in IDLE the stored pointer is the start point.
   assign base = (state == ST_HOLD) ? ptr_inc(sel_out) : ptr;

   rr_pick_8 u_pick (
      .req  (req),
      .ptr  (base),
      .pick (pick),
      .any  (any)
   );

   // 8:1 data mux steered by the current pick.
   always_comb begin
      mux_dat = in0;
      case (pick)
         3'd0:    mux_dat = in0;
         3'd1:    mux_dat = in1;
         3'd2:    mux_dat = in2;
         3'd3:    mux_dat = in3;
         3'd4:    mux_dat = in4;
         3'd5:    mux_dat = in5;
         3'd6:    mux_dat = in6;
         default: mux_dat = in7;
      endcase
   end

   // State, pointer and output registers; grant is a one-cycle pulse per capture.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= ST_IDLE;
         ptr       <= 3'd0;
         out       <= '0;
         out_valid <= 1'b0;
         sel_out   <= 3'd0;
         grant     <= '0;
      end else begin
         grant <= '0;
         case (state)
            ST_IDLE: begin
               if (any) begin
                  out         <= mux_dat;
                  sel_out     <= pick;
                  out_valid   <= 1'b1;
                  grant[pick] <= 1'b1;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  ptr <= base;
                  if (any) begin
                     out         <= mux_dat;
                     sel_out     <= pick;
                     grant[pick] <= 1'b1;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_8line_8bit_rr.sv
// Bench for the 8-line round-robin gathering mux.
// Latency: one cycle per step task; outputs sampled 1 time unit after the edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_mux_8line_8bit_rr;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] in_d [8];
   logic [7:0] req = 8'h00;
   logic       out_ready = 1'b0;
   logic [7:0] out;
   logic       out_valid;
   logic [2:0] sel_out;
   logic [7:0] grant;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic       m_valid = 1'b0;
   logic [2:0] m_ptr = 3'd0;
   logic [2:0] m_sel = 3'd0;
   logic [7:0] m_out = 8'h00;
   logic [10:0] sbq [$];

   always #5 clk = ~clk;

   mux_8line_8bit_rr dut (
      .clk       (clk),
      .clr       (clr),
      .in0       (in_d[0]),
      .in1       (in_d[1]),
      .in2       (in_d[2]),
      .in3       (in_d[3]),
      .in4       (in_d[4]),
      .in5       (in_d[5]),
      .in6       (in_d[6]),
      .in7       (in_d[7]),
      .req       (req),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .sel_out   (sel_out),
      .grant     (grant)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Returns the first requesting line starting at base, or -1 if none.
   function automatic int pick_of(input logic [7:0] r, input logic [2:0] base);
      for (int k = 0; k < 8; k++) begin
         if (r[(int'(base) + k) % 8]) return (int'(base) + k) % 8;
      end
      return -1;
   endfunction

   // One clock: predict the edge, push captures to the scoreboard, then compare.
   task automatic cyc();
      int         p;
      logic [2:0] base;
      logic       cap;
      logic [10:0] e;
      cap = 1'b0;
      if (!m_valid || out_ready) begin
         base = m_valid ? 3'(m_sel + 3'd1) : m_ptr;
         if (m_valid) m_ptr = base;
         p = pick_of(req, base);
         if (p >= 0) begin
            cap     = 1'b1;
            m_sel   = 3'(p);
            m_out   = in_d[p];
            m_valid = 1'b1;
            sbq.push_back({3'(p), in_d[p]});
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("grant", 32'(grant), cap ? (32'h1 << m_sel) : 32'h0);
      chk("out_hold", 32'(out), 32'(m_out));
      if (cap) begin
         if (sbq.size() == 0) begin
            chk("sb_empty", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq.pop_front();
            chk("sb_sel", 32'(sel_out), 32'(e[10:8]));
            chk("sb_data", 32'(out), 32'(e[7:0]));
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_out"}, 32'(out), 32'h0);
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_sel"}, 32'(sel_out), 32'h0);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      #1;
      check_cleared("rst");
      @(negedge clk);
      clr     = 1'b0;
      m_valid = 1'b0;
      m_ptr   = 3'd0;
      m_sel   = 3'd0;
      m_out   = 8'h00;
      sbq.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) in_d[i] = 8'h00;
      do_reset();

      // single request from line 0, then drain
      in_d[0] = 8'h07; req = 8'h01; out_ready = 1'b1;
      cyc();
      chk("t30_out", 32'(out), 32'h07);
      chk("t30_sel", 32'(sel_out), 32'h0);
      chk("t30_grant", 32'(grant), 32'h01);
      req = 8'h00;
      cyc();
      chk("t30_valid_off", 32'(out_valid), 32'h0);

      // all lines requesting: one byte per cycle in rotation
      do_reset();
      for (int i = 0; i < 8; i++) in_d[i] = 8'(i + 8'h10);
      req = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("t31_seq", 32'(sel_out), 32'(i % 8));
         chk("t31_dat", 32'(out), 32'((i % 8) + 16));
      end
      req = 8'h00;
      cyc();

      // wrap-around from pointer 7 (set by accepting line 6)
      do_reset();
      in_d[6] = 8'h66; in_d[7] = 8'h77; in_d[0] = 8'h70;
      req = 8'h40; out_ready = 1'b1;
      cyc();
      req = 8'h00;
      cyc();
      req = 8'h81;
      cyc();
      chk("t32_first", 32'(sel_out), 32'h7);
      cyc();
      chk("t32_wrap", 32'(sel_out), 32'h0);
      chk("t32_dat", 32'(out), 32'h70);
      req = 8'h00;
      cyc();

      // backpressure while holding line 3
      do_reset();
      in_d[3] = 8'hA5; req = 8'h08; out_ready = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         req = 8'($urandom);
         for (int j = 0; j < 8; j++) in_d[j] = 8'($urandom);
         cyc();
         chk("t33_out", 32'(out), 32'hA5);
         chk("t33_sel", 32'(sel_out), 32'h3);
         chk("t33_grant", 32'(grant), 32'h0);
      end
      req = 8'h00; out_ready = 1'b1;
      cyc();
      chk("t33_accept", 32'(out_valid), 32'h0);

      // idle with no requests
      for (int i = 0; i < 10; i++) begin
         in_d[i % 8] = 8'($urandom);
         cyc();
      end
      chk("t34_out", 32'(out), 32'hA5);

      // asynchronous clear mid-hold
      in_d[2] = 8'h42; req = 8'h04; out_ready = 1'b0;
      cyc();
      chk("t29_pre", 32'(out), 32'h42);
      req = 8'h00;
      #2;
      clr = 1'b1;
      #1;
      check_cleared("t29");
      do_reset();

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         req = 8'($urandom);
         if ($urandom_range(0, 3) == 0) req = 8'h00;
         out_ready = ($urandom_range(0, 2) != 0);
         for (int j = 0; j < 8; j++) in_d[j] = 8'($urandom);
         cyc();
         chk("rnd_sel", 32'(sel_out), 32'(m_sel));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
